mem_kxn_sweep: RTL and testbench

- Parametrised synchronous single-clock RAM, K bits wide by DEPTH words. It is the generalised successor to the fixed 8x1024 data memory and the 1x1024 display memory.
- Port A is read/write for the CPU/datapath. Port B is read-only, for display scan-out.
- A built-in clear engine sweeps every word to CLR_VAL after reset and on request, so software never sees uninitialised contents.

---
 rtl/mem_kxn_sweep.sv | 96 +++++++++
 tb/tb_mem_kxn_sweep.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_kxn_sweep.sv
// K-bit x DEPTH synchronous RAM with a read/write port A, a read-only port B
// and a clear engine that sweeps every word to CLR_VAL after reset and on clr.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_CLEAR | sweep writing CLR_VAL to mem[cnt]; user writes and clr ignored
// S_IDLE  | normal operation; port A read/write, port B read
module mem_kxn_sweep #(
   parameter int             K        = 8,
   parameter int             DEPTH    = 1024,
   parameter int             AW       = $clog2(DEPTH),
   parameter int             RDW_MODE = 0,
   parameter logic [K-1:0]   CLR_VAL  = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr,
   input  logic [AW-1:0] addr,
   input  logic [K-1:0]  d_i,
   output logic [K-1:0]  d_o,
   input  logic [AW-1:0] addr_b,
   output logic [K-1:0]  d_ob,
   input  logic          clr,
   output logic          busy
);

   localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

   typedef enum logic {S_CLEAR, S_IDLE} state_t;

   state_t        state;
   logic [AW-1:0] cnt;
   logic [K-1:0]  mem [DEPTH];

   logic          a_ok;
   logic          b_ok;
   logic          usr_wr;
   logic          we;
   logic [AW-1:0] wa;
   logic [K-1:0]  wd;

   // Single write path shared by the sweep and port A; sweep owns it in S_CLEAR,
   // and clr on an idle edge discards the user write.
   always_comb begin
      a_ok   = {1'b0, addr} < DEPTH_W;
      b_ok   = {1'b0, addr_b} < DEPTH_W;
      usr_wr = (state == S_IDLE) && !clr && wr && a_ok;
      we     = (state == S_CLEAR) || usr_wr;
      wa     = (state == S_CLEAR) ? cnt : addr;
      wd     = (state == S_CLEAR) ? CLR_VAL : d_i;
   end

   // Array write; no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   // Sweep FSM plus registered read ports.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_CLEAR;
         cnt   <= '0;
         busy  <= 1'b1;
         d_o   <= '0;
         d_ob  <= '0;
      end else begin
         case (state)
            S_CLEAR: begin
               d_o  <= CLR_VAL;
               d_ob <= CLR_VAL;
               if (cnt == LAST) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + AW'(1);
               end
            end
            S_IDLE: begin
               // Port B always sees pre-write content, even on a colliding write.
               if (!a_ok)                        d_o <= '0;
               else if (RDW_MODE != 0 && usr_wr) d_o <= d_i;
               else                              d_o <= mem[addr];
               d_ob <= b_ok ? mem[addr_b] : '0;
               if (clr) begin
                  state <= S_CLEAR;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            default: state <= S_CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_kxn_sweep.sv
// Directed bench for mem_kxn_sweep: two 8x1024 instances (old-data and
// write-through read-during-write) driven in lockstep, plus a 1x1000 instance
// with CLR_VAL=1 for the non-power-of-two configuration.
module tb_mem_kxn_sweep;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       wr, clr;
   logic [9:0] addr, addr_b;
   logic [7:0] d_i;
   logic [7:0] d_o0, d_ob0, d_o1, d_ob1;
   logic       busy0, busy1;

   logic       wr_k, clr_k, d_k;
   logic [9:0] addr_k, addr_bk;
   logic       d_ok, d_obk, busy_k;

   int n_chk  = 0;
   int n_pass = 0;

   mem_kxn_sweep #(.K(8), .DEPTH(1024), .RDW_MODE(0)) u_m0 (
      .clk(clk), .rst_n(rst_n), .wr(wr), .addr(addr), .d_i(d_i), .d_o(d_o0),
      .addr_b(addr_b), .d_ob(d_ob0), .clr(clr), .busy(busy0));

   mem_kxn_sweep #(.K(8), .DEPTH(1024), .RDW_MODE(1)) u_m1 (
      .clk(clk), .rst_n(rst_n), .wr(wr), .addr(addr), .d_i(d_i), .d_o(d_o1),
      .addr_b(addr_b), .d_ob(d_ob1), .clr(clr), .busy(busy1));

   mem_kxn_sweep #(.K(1), .DEPTH(1000), .CLR_VAL(1'b1)) u_k1 (
      .clk(clk), .rst_n(rst_n), .wr(wr_k), .addr(addr_k), .d_i(d_k), .d_o(d_ok),
      .addr_b(addr_bk), .d_ob(d_obk), .clr(clr_k), .busy(busy_k));

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_a(input int a, input logic [7:0] d);
      addr = 10'(a);
      d_i  = d;
      wr   = 1'b1;
      tick();
      wr   = 1'b0;
   endtask

   // Edges from reset release until each busy falls (0 = never fell).
   task automatic sweep_len(output int n0, output int n1, output int nk);
      n0 = 0; n1 = 0; nk = 0;
      for (int i = 1; i <= 1200; i++) begin
         tick();
         if (n0 == 0 && !busy0)  n0 = i;
         if (n1 == 0 && !busy1)  n1 = i;
         if (nk == 0 && !busy_k) nk = i;
         if (n0 != 0 && n1 != 0 && nk != 0) break;
      end
   endtask

   task automatic read_all(input logic [7:0] exp, output int errs);
      errs = 0;
      wr = 1'b0;
      for (int a = 0; a < 1024; a++) begin
         addr   = 10'(a);
         addr_b = 10'(1023 - a);
         tick();
         if (d_o0 != exp) errs++;
         if (d_ob0 != exp) errs++;
         if (d_o1 != exp) errs++;
         if (d_ob1 != exp) errs++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n0, n1, nk, errs, n;
      rst_n = 1'b0;
      wr = 1'b0; clr = 1'b0; addr = '0; addr_b = '0; d_i = '0;
      wr_k = 1'b0; clr_k = 1'b0; d_k = 1'b0; addr_k = '0; addr_bk = '0;
      #23;
      chk("rst_busy",   int'(busy0), 1);
      chk("rst_d_o",    int'(d_o0), 0);
      chk("rst_d_ob",   int'(d_ob0), 0);
      chk("rst_busy_k", int'(busy_k), 1);
      chk("rst_d_o_k",  int'(d_ok), 0);
      rst_n = 1'b1;
      sweep_len(n0, n1, nk);
      chk("sweep1_len_m0", n0, 1024);
      chk("sweep1_len_m1", n1, 1024);
      chk("sweep1_len_k1", nk, 1000);

      // Fill with 0xFF, then reset and confirm the sweep wipes it.
      for (int a = 0; a < 1024; a++) wr_a(a, 8'hFF);
      addr = 10'd10; tick();
      chk("preload_ff", int'(d_o0), 8'hFF);
      #2 rst_n = 1'b0;
      #10 rst_n = 1'b1;
      sweep_len(n0, n1, nk);
      chk("sweep2_len_m0", n0, 1024);
      chk("sweep2_len_k1", nk, 1000);
      read_all(8'h00, errs);
      chk("sweep2_all_zero", errs, 0);

      // Basic read/write.
      wr_a(3, 8'h5A);
      wr_a(1023, 8'hA5);
      addr = 10'd3; addr_b = 10'd1023; tick();
      chk("rd_a_3", int'(d_o0), 8'h5A);
      chk("rd_b_1023", int'(d_ob0), 8'hA5);
      addr = 10'd4; tick();
      chk("rd_a_4", int'(d_o0), 8'h00);

      // Read-during-write at address 7.
      wr_a(7, 8'h22);
      addr = 10'd7; addr_b = 10'd7; d_i = 8'h11; wr = 1'b1;
      tick();
      wr = 1'b0;
      chk("rdw_old_m0", int'(d_o0), 8'h22);
      chk("rdw_new_m1", int'(d_o1), 8'h11);
      chk("rdw_b_m0",   int'(d_ob0), 8'h22);
      chk("rdw_b_m1",   int'(d_ob1), 8'h22);
      tick();
      chk("rdw_after_m0", int'(d_o0), 8'h11);
      chk("rdw_after_m1", int'(d_o1), 8'h11);

      // clr has priority over a same-edge write; wr during the sweep is ignored.
      wr_a(5, 8'h44);
      clr = 1'b1; wr = 1'b1; addr = 10'd5; addr_b = 10'd5; d_i = 8'h33;
      tick();
      clr = 1'b0; wr = 1'b0;
      chk("clr_busy",    int'(busy0), 1);
      chk("clr_d_o_m0",  int'(d_o0), 8'h44);
      chk("clr_d_o_m1",  int'(d_o1), 8'h44);
      chk("clr_d_ob_m0", int'(d_ob0), 8'h44);
      n = 1;
      for (int i = 0; i < 1200 && busy0; i++) begin
         wr   = (i % 3) == 0;
         addr = 10'(i / 2);
         d_i  = 8'h77;
         tick();
         n++;
      end
      wr = 1'b0;
      chk("clr_busy_edges", n, 1025);
      chk("clr_busy_m1", int'(busy1), 0);
      read_all(8'h00, errs);
      chk("clr_all_zero", errs, 0);

      // Asynchronous reset during normal operation, then mid-sweep.
      wr_a(3, 8'h5A);
      addr = 10'd3; addr_b = 10'd3; tick();
      chk("pre_rst_d_o", int'(d_o0), 8'h5A);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_d_o",  int'(d_o0), 0);
      chk("arst_d_ob", int'(d_ob0), 0);
      chk("arst_busy", int'(busy0), 1);
      #10 rst_n = 1'b1;
      for (int i = 0; i < 500; i++) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", int'(busy0), 1);
      #10 rst_n = 1'b1;
      sweep_len(n0, n1, nk);
      chk("sweep3_len_m0", n0, 1024);
      chk("sweep3_len_m1", n1, 1024);
      chk("sweep3_len_k1", nk, 1000);

      // K=1, DEPTH=1000, CLR_VAL=1 instance.
      wr_k = 1'b1; addr_k = 10'd999;  d_k = 1'b0; tick();
      addr_k = 10'd1000; d_k = 1'b0; tick();
      wr_k = 1'b0;
      addr_k = 10'd999; addr_bk = 10'd1000; tick();
      chk("k1_rd_999",   int'(d_ok), 0);
      chk("k1_rdb_1000", int'(d_obk), 0);
      addr_k = 10'd1000; addr_bk = 10'd999; tick();
      chk("k1_rd_1000",  int'(d_ok), 0);
      chk("k1_rdb_999",  int'(d_obk), 0);
      addr_k = 10'd1023; tick();
      chk("k1_rd_1023", int'(d_ok), 0);
      errs = 0;
      for (int a = 0; a < 999; a++) begin
         addr_k  = 10'(a);
         addr_bk = 10'(998 - a);
         tick();
         if (d_ok != 1'b1) errs++;
         if (d_obk != 1'b1) errs++;
      end
      chk("k1_all_one", errs, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
